qsys_device_bridge: RTL and testbench
=====================================

// Module: qsys_device_bridge
// PURPOSE
//   Registered Avalon-MM slave to device-port bridge; parametrised successor of the pass-through Qsys device shim.
//   Captures each Qsys transfer and replays it on the device port. Honours device_waitrequest.
//   Adds byte enables, a per-transfer timeout and a sticky error flag.
//   Sits between the Qsys interconnect and one custom peripheral.
// PARAMETERS
//   ADDR_W   8    address width, both sides
//   DATA_W   8    data width, both sides; multiple of 8; byteenable width BE_W = DATA_W/8
//   TIMEOUT  255  max device wait cycles before abort; 0 = wait forever
// PORTS
//   csi_MCLK_clk          in   1       single clock; all logic rising-edge
//   rsi_MRST_reset        in   1       asynchronous, active-high reset
//   avs_ctrl_address      in   ADDR_W  Qsys word address
//   avs_ctrl_writedata    in   DATA_W  Qsys write data
//   avs_ctrl_byteenable   in   BE_W    Qsys byte enables
//   avs_ctrl_write        in   1       Qsys write request
//   avs_ctrl_read         in   1       Qsys read request
//   avs_ctrl_readdata     out  DATA_W  registered read data
//   avs_ctrl_waitrequest  out  1       stall to Qsys master
//   device_reset          out  1       = rsi_MRST_reset (combinational)
//   device_clk            out  1       = csi_MCLK_clk (combinational)
//   device_address        out  ADDR_W  registered address
//   device_writedata      out  DATA_W  registered write data
//   device_byteenable     out  BE_W    registered byte enables
//   device_write          out  1       device write strobe
//   device_read           out  1       device read strobe
//   device_readdata       in   DATA_W  device read data; valid when device_waitrequest=0
//   device_waitrequest    in   1       device stall
//   timeout_err           out  1       sticky: a transfer was aborted
//   timeout_clr           in   1       sync clear of timeout_err; set wins if same cycle
// BEHAVIOUR
//   FSM IDLE -> ISSUE -> DONE -> IDLE; reset state IDLE.
//   Reset values (async): device_* regs, avs_ctrl_readdata, wait counter 0; timeout_err 0; strobes 0.
//   avs_ctrl_waitrequest = (state != DONE); it is therefore 1 during reset and in IDLE.
//   IDLE, write|read seen:
//     - capture address, writedata and byteenable; latch op; goto ISSUE.
//     - write and read in the same cycle (illegal): write wins; read dropped.
//   ISSUE:
//     - device_write or device_read = 1 with the latched op; address, data and byteenable stable.
//     - device_waitrequest=0: read captures device_readdata into avs_ctrl_readdata; strobes drop; goto DONE.
//     - device_waitrequest=1: counter++.
//     - TIMEOUT!=0, counter==TIMEOUT and still waiting: abort.
//       Abort: readdata = all ones (read only); timeout_err=1; goto DONE.
//     - Strobe is therefore high for at most TIMEOUT+1 cycles.
//   DONE: one cycle; waitrequest=0 completes the Qsys transfer; readdata held; counter cleared; goto IDLE.
//   Latency: request cycle 0; device strobe cycles 1..1+W (W = device wait states); Qsys completion cycle 2+W.
//   Back-to-back: a new request is accepted in the IDLE cycle following DONE (3-cycle minimum per transfer).
//   avs_ctrl_readdata holds its last value until the next read completes; writes do not alter it.
//   Counter width = clog2(TIMEOUT+1); minimum 1 bit; never wraps (abort precedes overflow).
//   Reset mid-transfer: strobes drop immediately (async); FSM returns to IDLE; no completion is issued.
// TESTING
//   Write A=0x12 D=0xA5 BE=1, device_waitrequest=0:
//     device_write=1 only in cycle 1 with 0x12/0xA5/1; avs waitrequest=0 in cycle 2 only.
//   Read A=0x34, device waits 3 cycles then returns 0x3C:
//     device_read=1 for cycles 1-4; avs_ctrl_readdata=0x3C with waitrequest=0 in cycle 5.
//   TIMEOUT=4, device_waitrequest stuck 1 on a read:
//     device_read=1 for exactly 5 cycles; readdata=0xFF; timeout_err=1.
//     Then timeout_clr pulse -> timeout_err=0.
//   Read and write asserted together (D=0x5A): only device_write pulses; device_read stays 0.
//   rsi_MRST_reset pulse during ISSUE: device_read=0 immediately; FSM in IDLE.
//     A fresh read afterwards completes normally.
//   DATA_W=32 build, BE=4'b0110, TIMEOUT=0, device waits 1000 cycles:
//     no abort; byteenable passed through; completes in cycle 1002.

Source files
------------

// File: rtl/qsys_device_bridge.sv
// Registered Avalon-MM slave to device-port bridge.
// Each Qsys transfer is captured, replayed on the device port, and completed
// one cycle after the device stops stalling. If the device stalls for longer
// than TIMEOUT cycles, the transfer is aborted and a sticky error flag is set.
module qsys_device_bridge #(
    parameter  int ADDR_W  = 8,
    parameter  int DATA_W  = 8,
    parameter  int TIMEOUT = 255,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic              csi_MCLK_clk,
    input  logic              rsi_MRST_reset,
    input  logic [ADDR_W-1:0] avs_ctrl_address,
    input  logic [DATA_W-1:0] avs_ctrl_writedata,
    input  logic [BE_W-1:0]   avs_ctrl_byteenable,
    input  logic              avs_ctrl_write,
    input  logic              avs_ctrl_read,
    output logic [DATA_W-1:0] avs_ctrl_readdata,
    output logic              avs_ctrl_waitrequest,
    output logic              device_reset,
    output logic              device_clk,
    output logic [ADDR_W-1:0] device_address,
    output logic [DATA_W-1:0] device_writedata,
    output logic [BE_W-1:0]   device_byteenable,
    output logic              device_write,
    output logic              device_read,
    input  logic [DATA_W-1:0] device_readdata,
    input  logic              device_waitrequest,
    output logic              timeout_err,
    input  logic              timeout_clr
);

    // Wait counter only has to reach TIMEOUT; one bit when timeouts are disabled.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               op_write_reg;   // 1 = write, 0 = read
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [BE_W-1:0]    be_reg;
    logic [DATA_W-1:0]  rdata_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               err_reg;
    logic               accept;
    logic               complete;
    logic               abort_now;

    // Clock and reset are forwarded untouched to the peripheral.
    assign device_clk        = csi_MCLK_clk;
    assign device_reset      = rsi_MRST_reset;
    assign device_address    = addr_reg;
    assign device_writedata  = wdata_reg;
    assign device_byteenable = be_reg;
    assign avs_ctrl_readdata = rdata_reg;
    assign timeout_err       = err_reg;

    // FSM state register.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and strobes; write wins when both requests arrive together.
    always_comb begin
        state_next           = state_reg;
        accept               = 1'b0;
        complete             = 1'b0;
        abort_now            = 1'b0;
        device_write         = 1'b0;
        device_read          = 1'b0;
        avs_ctrl_waitrequest = 1'b1;
        case (state_reg)
            IDLE: begin
                if (avs_ctrl_write || avs_ctrl_read) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                device_write = op_write_reg;
                device_read  = !op_write_reg;
                if (!device_waitrequest) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end else if ((TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT))) begin
                    abort_now  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                avs_ctrl_waitrequest = 1'b0;
                state_next           = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the Qsys request; held stable for the whole device phase.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            addr_reg     <= '0;
            wdata_reg    <= '0;
            be_reg       <= '0;
            op_write_reg <= 1'b0;
        end else if (accept) begin
            addr_reg     <= avs_ctrl_address;
            wdata_reg    <= avs_ctrl_writedata;
            be_reg       <= avs_ctrl_byteenable;
            op_write_reg <= avs_ctrl_write;
        end
    end

    // Read data: device data on completion, all ones on an aborted read.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            rdata_reg <= '0;
        end else if (!op_write_reg) begin
            if (complete) begin
                rdata_reg <= device_readdata;
            end else if (abort_now) begin
                rdata_reg <= '1;
            end
        end
    end

    // Wait-state counter; stops at TIMEOUT because the abort fires there.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            cnt_reg <= '0;
        end else if (state_reg == DONE) begin
            cnt_reg <= '0;
        end else if ((TIMEOUT != 0) && (state_reg == ISSUE) && device_waitrequest && !abort_now) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Sticky abort flag; a new abort overrides a simultaneous clear.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            err_reg <= 1'b0;
        end else if (abort_now) begin
            err_reg <= 1'b1;
        end else if (timeout_clr) begin
            err_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qsys_device_bridge.sv
// Bench for qsys_device_bridge: an 8-bit build with TIMEOUT=4 and a 32-bit
// build with timeouts disabled, checked every cycle against a transfer-level
// timing model plus a few literal expectations.
`timescale 1ns/1ps
module tb_qsys_device_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Instance A: DATA_W=8, TIMEOUT=4
    logic       rst_a, a_write, a_read, a_waitreq, a_dclk, a_drst, a_dw, a_dr, a_dwait, a_err, a_clr;
    logic [7:0] a_addr, a_wdata, a_rdata, a_daddr, a_dwdata, a_drdata;
    logic [0:0] a_be, a_dbe;

    // Instance B: DATA_W=32, TIMEOUT=0
    logic        rst_b, b_write, b_read, b_waitreq, b_dclk, b_drst, b_dw, b_dr, b_dwait, b_err, b_clr;
    logic [7:0]  b_addr, b_daddr;
    logic [31:0] b_wdata, b_rdata, b_dwdata, b_drdata;
    logic [3:0]  b_be, b_dbe;

    qsys_device_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut_a (
        .csi_MCLK_clk(clk), .rsi_MRST_reset(rst_a),
        .avs_ctrl_address(a_addr), .avs_ctrl_writedata(a_wdata), .avs_ctrl_byteenable(a_be),
        .avs_ctrl_write(a_write), .avs_ctrl_read(a_read),
        .avs_ctrl_readdata(a_rdata), .avs_ctrl_waitrequest(a_waitreq),
        .device_reset(a_drst), .device_clk(a_dclk),
        .device_address(a_daddr), .device_writedata(a_dwdata), .device_byteenable(a_dbe),
        .device_write(a_dw), .device_read(a_dr),
        .device_readdata(a_drdata), .device_waitrequest(a_dwait),
        .timeout_err(a_err), .timeout_clr(a_clr)
    );

    qsys_device_bridge #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(0)) dut_b (
        .csi_MCLK_clk(clk), .rsi_MRST_reset(rst_b),
        .avs_ctrl_address(b_addr), .avs_ctrl_writedata(b_wdata), .avs_ctrl_byteenable(b_be),
        .avs_ctrl_write(b_write), .avs_ctrl_read(b_read),
        .avs_ctrl_readdata(b_rdata), .avs_ctrl_waitrequest(b_waitreq),
        .device_reset(b_drst), .device_clk(b_dclk),
        .device_address(b_daddr), .device_writedata(b_dwdata), .device_byteenable(b_dbe),
        .device_write(b_dw), .device_read(b_dr),
        .device_readdata(b_drdata), .device_waitrequest(b_dwait),
        .timeout_err(b_err), .timeout_clr(b_clr)
    );

    // Transfer-level model: one outstanding transfer per instance, timed from its request cycle.
    bit          m_active [2];
    int          m_t0     [2];
    bit          m_wr     [2];
    bit          m_rd     [2];
    logic [7:0]  m_addr   [2];
    logic [31:0] m_data   [2];
    logic [3:0]  m_be     [2];
    int          m_w      [2];
    int          m_tmo    [2];
    logic [31:0] m_rdv    [2];
    logic [31:0] m_hold   [2];
    bit          m_err    [2];
    logic [31:0] m_mask   [2];

    function automatic bit aborts(input int i);
        return (m_tmo[i] != 0) && (m_w[i] > m_tmo[i]);
    endfunction

    // Device wait cycles actually spent before the device phase ends.
    function automatic int eff(input int i);
        return aborts(i) ? m_tmo[i] : m_w[i];
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cyc=%0d actual=%h expected=%h", name, i, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                logic        aw, ar, aq, aerr, adrst, arst;
                logic [31:0] ard, adw;
                logic [7:0]  ada;
                logic [3:0]  abe;
                int          r, e;
                bit          ab, ew, er, eq, eerr;
                logic [31:0] erd;
                if (i == 0) begin
                    aw = a_dw; ar = a_dr; aq = a_waitreq; aerr = a_err; ard = {24'h0, a_rdata};
                    adw = {24'h0, a_dwdata}; ada = a_daddr; abe = {3'b0, a_dbe}; adrst = a_drst; arst = rst_a;
                end else begin
                    aw = b_dw; ar = b_dr; aq = b_waitreq; aerr = b_err; ard = b_rdata;
                    adw = b_dwdata; ada = b_daddr; abe = b_dbe; adrst = b_drst; arst = rst_b;
                end
                e    = eff(i);
                ab   = aborts(i);
                r    = cyc - m_t0[i];
                ew   = m_active[i] && m_wr[i] && (r >= 1) && (r <= e + 1);
                er   = m_active[i] && m_rd[i] && (r >= 1) && (r <= e + 1);
                eq   = !(m_active[i] && (r == e + 2));
                erd  = (m_active[i] && m_rd[i] && (r >= e + 2)) ? (ab ? m_mask[i] : m_rdv[i]) : m_hold[i];
                eerr = m_err[i] | (m_active[i] && ab && (r >= e + 2));
                chk("device_write", i, {31'b0, aw}, {31'b0, ew});
                chk("device_read", i, {31'b0, ar}, {31'b0, er});
                chk("avs_waitrequest", i, {31'b0, aq}, {31'b0, eq});
                chk("avs_readdata", i, ard, erd);
                chk("timeout_err", i, {31'b0, aerr}, {31'b0, eerr});
                chk("device_reset", i, {31'b0, adrst}, {31'b0, arst});
                if (ew || er) begin
                    chk("device_address", i, {24'h0, ada}, {24'h0, m_addr[i]});
                    chk("device_writedata", i, adw, m_data[i]);
                    chk("device_byteenable", i, {28'h0, abe}, {28'h0, m_be[i]});
                end
            end
            chk("device_clk", 0, {31'b0, a_dclk}, {31'b0, clk});
        end
    end

    // Strobe-cycle counters and B's completion cycle, used by the literal checks.
    int cnt_aw = 0, cnt_ar = 0, b_done_cyc = 0;
    always @(negedge clk) begin
        if (a_dw) cnt_aw++;
        if (a_dr) cnt_ar++;
        if (!b_waitreq && !rst_b) b_done_cyc = cyc;
    end

    task automatic drive_req(input int i, input bit wr, input bit rd, input logic [7:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
        if (i == 0) begin
            a_write = wr; a_read = rd; a_addr = addr; a_wdata = data[7:0]; a_be = be[0];
        end else begin
            b_write = wr; b_read = rd; b_addr = addr; b_wdata = data; b_be = be;
        end
    endtask

    task automatic drive_dev(input int i, input bit wt, input logic [31:0] rd);
        if (i == 0) begin
            a_dwait = wt; a_drdata = rd[7:0];
        end else begin
            b_dwait = wt; b_drdata = rd;
        end
    endtask

    // Start a transfer in the current cycle (request cycle 0) and note it in the model.
    task automatic start_xfer(input int i, input bit wr, input bit rd, input logic [7:0] addr,
                              input logic [31:0] data, input logic [3:0] be, input int w,
                              input logic [31:0] rdv);
        m_t0[i] = cyc; m_wr[i] = wr; m_rd[i] = rd && !wr; m_addr[i] = addr;
        m_data[i] = data & m_mask[i]; m_be[i] = (i == 0) ? (be & 4'h1) : be;
        m_w[i] = w; m_rdv[i] = rdv & m_mask[i]; m_active[i] = 1'b1;
        drive_req(i, wr, rd, addr, data, be);
        drive_dev(i, 1'b1, 32'hEEEE_EEEE);
    endtask

    // Full transfer: device stalls w cycles then answers with rdv; master holds request until DONE.
    task automatic xfer(input int i, input bit wr, input bit rd, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] be, input int w,
                        input logic [31:0] rdv);
        int e;
        @(posedge clk); #1;
        start_xfer(i, wr, rd, addr, data, be, w, rdv);
        e = eff(i);
        for (int r = 1; r <= e + 2; r++) begin
            @(posedge clk); #1;
            if (r == w + 1) drive_dev(i, 1'b0, rdv);
            else            drive_dev(i, 1'b1, 32'hEEEE_EEEE);
        end
        @(posedge clk); #1;
        drive_req(i, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        if (m_rd[i]) m_hold[i] = aborts(i) ? m_mask[i] : m_rdv[i];
        if (aborts(i)) m_err[i] = 1'b1;
        m_active[i] = 1'b0;
    endtask

    int base_w, base_r;

    initial begin
        m_tmo[0] = 4; m_tmo[1] = 0;
        m_mask[0] = 32'h0000_00FF; m_mask[1] = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_t0[i] = 0; m_hold[i] = '0; m_err[i] = 1'b0; m_w[i] = 0;
        end
        rst_a = 1'b1; rst_b = 1'b1; a_clr = 1'b0; b_clr = 1'b0;
        drive_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        drive_req(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        drive_dev(0, 1'b1, 32'h0);
        drive_dev(1, 1'b1, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_waitrequest", 0, {31'b0, a_waitreq}, 32'd1);
        chk("reset_device_read", 0, {31'b0, a_dr}, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0; cmp_en = 1'b1;
        #1;
        chk("reset_readdata", 0, {24'h0, a_rdata}, 32'h0);
        chk("reset_timeout_err", 0, {31'b0, a_err}, 32'd0);

        // Zero-wait write
        base_w = cnt_aw;
        xfer(0, 1'b1, 1'b0, 8'h12, 32'hA5, 4'h1, 0, 32'h0);
        chk("write_strobe_cycles", 0, cnt_aw - base_w, 32'd1);

        // Read with three device wait states
        base_r = cnt_ar;
        xfer(0, 1'b0, 1'b1, 8'h34, 32'h0, 4'h1, 3, 32'h3C);
        chk("read_strobe_cycles", 0, cnt_ar - base_r, 32'd4);
        chk("read_data_literal", 0, {24'h0, a_rdata}, 32'h3C);

        // Stuck device: abort after TIMEOUT+1 strobe cycles
        base_r = cnt_ar;
        xfer(0, 1'b0, 1'b1, 8'h77, 32'h0, 4'h1, 100, 32'h11);
        chk("abort_strobe_cycles", 0, cnt_ar - base_r, 32'd5);
        chk("abort_data_literal", 0, {24'h0, a_rdata}, 32'hFF);
        chk("abort_err_literal", 0, {31'b0, a_err}, 32'd1);

        // Clear the sticky flag
        @(posedge clk); #1; a_clr = 1'b1;
        @(posedge clk); #1; a_clr = 1'b0; m_err[0] = 1'b0;
        chk("clear_err_literal", 0, {31'b0, a_err}, 32'd0);

        // Read and write together: only the write is replayed
        base_w = cnt_aw; base_r = cnt_ar;
        xfer(0, 1'b1, 1'b1, 8'h21, 32'h5A, 4'h1, 0, 32'h0);
        chk("rw_write_cycles", 0, cnt_aw - base_w, 32'd1);
        chk("rw_read_cycles", 0, cnt_ar - base_r, 32'd0);
        chk("rw_readdata_held", 0, {24'h0, a_rdata}, 32'hFF);

        // Reset during the device phase
        @(posedge clk); #1;
        start_xfer(0, 1'b0, 1'b1, 8'h66, 32'h0, 4'h1, 10, 32'h0);
        @(posedge clk); #1;
        chk("pre_reset_read", 0, {31'b0, a_dr}, 32'd1);
        @(posedge clk); #1;
        rst_a = 1'b1;
        m_active[0] = 1'b0; m_hold[0] = '0; m_err[0] = 1'b0;
        drive_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        #1;
        chk("reset_drops_read", 0, {31'b0, a_dr}, 32'd0);
        chk("reset_idle_wait", 0, {31'b0, a_waitreq}, 32'd1);
        @(posedge clk); #1;
        rst_a = 1'b0;

        // Fresh read after reset
        xfer(0, 1'b0, 1'b1, 8'h56, 32'h0, 4'h1, 2, 32'h81);
        chk("post_reset_read_literal", 0, {24'h0, a_rdata}, 32'h81);

        // Wide build, no timeout, 1000 wait states, partial byte enables
        xfer(1, 1'b0, 1'b1, 8'h9A, 32'h0, 4'b0110, 1000, 32'hDEAD_BEEF);
        chk("wide_done_cycle", 1, b_done_cyc - m_t0[1], 32'd1002);
        chk("wide_read_literal", 1, b_rdata, 32'hDEAD_BEEF);
        chk("wide_no_abort", 1, {31'b0, b_err}, 32'd0);

        // Back-to-back wide write
        xfer(1, 1'b1, 1'b0, 8'h3B, 32'h1234_5678, 4'b1001, 1, 32'h0);
        chk("wide_write_keeps_readdata", 1, b_rdata, 32'hDEAD_BEEF);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
